// File: rtl/rptr_handler.sv
// Read-side pointer handler of the asynchronous FIFO: synchronises the Gray write
// pointer into r_clk and maintains the read pointers, status flags and fill level.
module rptr_handler #(
  parameter int PTR_WIDTH = 4,
  parameter int AE_THRESH = 1
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_en,
  input  logic                 clr_underflow,
  input  logic [PTR_WIDTH-1:0] g_wptr,
  output logic [PTR_WIDTH-1:0] b_rptr,
  output logic [PTR_WIDTH-1:0] g_rptr,
  output logic                 rd_fire,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH-1:0] rd_level,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH-1:0] AE_T = PTR_WIDTH'(AE_THRESH);

  logic [PTR_WIDTH-1:0] g_wptr_q1;
  logic [PTR_WIDTH-1:0] g_wptr_s;
  logic [PTR_WIDTH-1:0] b_wptr_s;
  logic [PTR_WIDTH-1:0] b_next;
  logic [PTR_WIDTH-1:0] g_next;
  logic [PTR_WIDTH-1:0] level_next;

  // Handshake: r_en is a request, !empty acts as ready; a read is consumed
  // (pointer advances, RAM strobed) only in a cycle where rd_fire = r_en & ~empty.
  assign rd_fire = r_en & ~empty;

  assign b_next     = b_rptr + {{(PTR_WIDTH-1){1'b0}}, rd_fire};
  assign g_next     = b_next ^ (b_next >> 1);
  assign level_next = b_wptr_s - b_next;

  // Gray to binary: XOR prefix running down from the MSB.
  always_comb begin
    b_wptr_s = '0;
    b_wptr_s[PTR_WIDTH-1] = g_wptr_s[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b_wptr_s[i] = b_wptr_s[i+1] ^ g_wptr_s[i];
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      g_wptr_q1 <= '0;
      g_wptr_s  <= '0;
    end else begin
      g_wptr_q1 <= g_wptr;
      g_wptr_s  <= g_wptr_q1;
    end
  end

  // Flags are computed from the post-increment pointer so empty asserts on the
  // same edge the last entry is consumed.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= b_next;
      g_rptr       <= g_next;
      empty        <= (g_next == g_wptr_s);
      almost_empty <= (level_next <= AE_T);
      rd_level     <= level_next;
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_handler.sv
// Directed bench for rptr_handler: reset, fill visibility, drain, underflow,
// pointer wrap and asynchronous mid-operation reset.
module tb_rptr_handler;

  localparam int W = 4;

  logic         r_clk;
  logic         r_rst;
  logic         r_en;
  logic         clr_underflow;
  logic [W-1:0] g_wptr;
  logic [W-1:0] b_rptr;
  logic [W-1:0] g_rptr;
  logic         rd_fire;
  logic         empty;
  logic         almost_empty;
  logic [W-1:0] rd_level;
  logic         underflow;

  int n_cmp = 0;
  int n_err = 0;

  // {b_rptr, g_rptr} pairs expected after each read edge
  logic [2*W-1:0] exp_q[$];

  rptr_handler #(.PTR_WIDTH(W), .AE_THRESH(1)) dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .r_en         (r_en),
    .clr_underflow(clr_underflow),
    .g_wptr       (g_wptr),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .rd_fire      (rd_fire),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  // clock / reset
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic e, input logic ae,
                              input logic [W-1:0] lvl);
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    check({tag, ".rd_level"}, 32'(rd_level), 32'(lvl));
  endtask

  // Issue one read per queued entry and compare both pointers after each edge.
  task automatic read_and_score(input string tag);
    logic [2*W-1:0] e;
    r_en = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check({tag, ".b_rptr"}, 32'(b_rptr), 32'(e[2*W-1:W]));
      check({tag, ".g_rptr"}, 32'(g_rptr), 32'(e[W-1:0]));
    end
    r_en = 1'b0;
  endtask

  initial begin
    r_rst = 1'b0;
    r_en = 1'b1;
    clr_underflow = 1'b0;
    g_wptr = 4'b0000;

    // Reset state, with r_en held high
    tick();
    tick();
    check("rst.b_rptr", 32'(b_rptr), 0);
    check("rst.g_rptr", 32'(g_rptr), 0);
    check_status("rst", 1'b1, 1'b1, 4'd0);
    check("rst.underflow", 32'(underflow), 0);
    check("rst.rd_fire", 32'(rd_fire), 0);

    // Release mid-cycle, then fill visibility latency
    r_en = 1'b0;
    #2 r_rst = 1'b1;
    tick();
    tick();
    check_status("idle", 1'b1, 1'b1, 4'd0);
    g_wptr = 4'b0010;  // bin 3
    tick();
    check_status("fill.e1", 1'b1, 1'b1, 4'd0);
    tick();
    check_status("fill.e2", 1'b1, 1'b1, 4'd0);
    tick();
    check_status("fill.e3", 1'b0, 1'b0, 4'd3);

    // Drain three entries, then a fourth read against empty
    r_en = 1'b1;
    #1;
    check("drain.rd_fire0", 32'(rd_fire), 1);
    tick();
    check("drain1.b", 32'(b_rptr), 1);
    check("drain1.g", 32'(g_rptr), 4'b0001);
    check_status("drain1", 1'b0, 1'b0, 4'd2);
    tick();
    check("drain2.b", 32'(b_rptr), 2);
    check("drain2.g", 32'(g_rptr), 4'b0011);
    check_status("drain2", 1'b0, 1'b1, 4'd1);
    tick();
    check("drain3.b", 32'(b_rptr), 3);
    check("drain3.g", 32'(g_rptr), 4'b0010);
    check_status("drain3", 1'b1, 1'b1, 4'd0);
    check("drain3.underflow", 32'(underflow), 0);
    check("drain4.rd_fire", 32'(rd_fire), 0);
    tick();
    check("drain4.b", 32'(b_rptr), 3);
    check("drain4.g", 32'(g_rptr), 4'b0010);
    check("drain4.underflow", 32'(underflow), 1);

    // Underflow clear, then simultaneous set and clear
    r_en = 1'b0;
    clr_underflow = 1'b1;
    tick();
    check("uf.clear", 32'(underflow), 0);
    r_en = 1'b1;
    tick();
    check("uf.set_wins", 32'(underflow), 1);
    r_en = 1'b0;
    tick();
    check("uf.clear2", 32'(underflow), 0);
    clr_underflow = 1'b0;

    // Advance to b_rptr = 6: write pointer to bin 6 (gray 0101), read 3
    g_wptr = 4'b0101;
    tick(); tick(); tick();
    check_status("pre6", 1'b0, 1'b0, 4'd3);
    exp_q.push_back({4'd4, 4'b0110});
    exp_q.push_back({4'd5, 4'b0111});
    exp_q.push_back({4'd6, 4'b0101});
    read_and_score("to6");
    check("to6.empty", 32'(empty), 1);

    // Full FIFO: write pointer bin 14 (gray 1001), level 8
    g_wptr = 4'b1001;
    tick(); tick(); tick();
    check_status("full", 1'b0, 1'b0, 4'd8);
    exp_q.push_back({4'd7,  4'b0100});
    exp_q.push_back({4'd8,  4'b1100});
    exp_q.push_back({4'd9,  4'b1101});
    exp_q.push_back({4'd10, 4'b1111});
    exp_q.push_back({4'd11, 4'b1110});
    exp_q.push_back({4'd12, 4'b1010});
    exp_q.push_back({4'd13, 4'b1011});
    exp_q.push_back({4'd14, 4'b1001});
    read_and_score("read8");
    check_status("read8.end", 1'b1, 1'b1, 4'd0);

    // Wrap: write pointer bin 2 (gray 0011), level 4 across the wrap
    g_wptr = 4'b0011;
    tick(); tick(); tick();
    check_status("wrap", 1'b0, 1'b0, 4'd4);
    exp_q.push_back({4'd15, 4'b1000});
    exp_q.push_back({4'd0,  4'b0000});
    exp_q.push_back({4'd1,  4'b0001});
    exp_q.push_back({4'd2,  4'b0011});
    read_and_score("wrap");
    check_status("wrap.end", 1'b1, 1'b1, 4'd0);

    // Set underflow so the mid-operation reset has a sticky flag to clear
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("pre_rst.underflow", 32'(underflow), 1);

    // Level 3 ahead of b_rptr = 2: write pointer bin 5 (gray 0111)
    g_wptr = 4'b0111;
    tick(); tick(); tick();
    check_status("pre_rst", 1'b0, 1'b0, 4'd3);

    // Asynchronous reset between edges
    #3 r_rst = 1'b0;
    #1;
    check("arst.b_rptr", 32'(b_rptr), 0);
    check("arst.g_rptr", 32'(g_rptr), 0);
    check_status("arst", 1'b1, 1'b1, 4'd0);
    check("arst.underflow", 32'(underflow), 0);
    g_wptr = 4'b0010;
    tick();
    #2 r_rst = 1'b1;
    tick();
    check_status("resync.e1", 1'b1, 1'b1, 4'd0);
    tick();
    check_status("resync.e2", 1'b1, 1'b1, 4'd0);
    tick();
    check_status("resync.e3", 1'b0, 1'b0, 4'd3);
    check("resync.b_rptr", 32'(b_rptr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
